// File: rtl/rvfi_serial_pkg.sv
// Shared record layout and helpers for the RVFI order serializer.
// A slot record is {8 XLEN fields, rmask, wmask, header}; the header sits at bit 0.
package rvfi_serial_pkg;

  localparam int unsigned ORDER_W = 8;
  localparam int unsigned INSN_W  = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned HDR_W   = ORDER_W + INSN_W + 3 * REG_W + 1;
  localparam int unsigned NXFIELD = 8;

  typedef struct packed {
    logic [ORDER_W-1:0] order;
    logic [INSN_W-1:0]  insn;
    logic [REG_W-1:0]   rs1;
    logic [REG_W-1:0]   rs2;
    logic [REG_W-1:0]   rd;
    logic               trap;
  } rvfi_hdr_t;

  function automatic int unsigned rec_width(input int unsigned xlen);
    return HDR_W + NXFIELD * xlen + 2 * (xlen / 8);
  endfunction

  // Masks follow the header; XLEN fields start above both masks.
  function automatic int unsigned data_off(input int unsigned xlen);
    return HDR_W + 2 * (xlen / 8);
  endfunction

  function automatic logic [HDR_W-1:0] pack_hdr(
    input logic [ORDER_W-1:0] order,
    input logic [INSN_W-1:0]  insn,
    input logic [REG_W-1:0]   rs1,
    input logic [REG_W-1:0]   rs2,
    input logic [REG_W-1:0]   rd,
    input logic               trap
  );
    rvfi_hdr_t h;
    h.order = order;
    h.insn  = insn;
    h.rs1   = rs1;
    h.rs2   = rs2;
    h.rd    = rd;
    h.trap  = trap;
    return h;
  endfunction

  function automatic rvfi_hdr_t unpack_hdr(input logic [HDR_W-1:0] v);
    return rvfi_hdr_t'(v);
  endfunction

  // Modulo-256 distance of an order ahead of the expected one.
  function automatic logic [ORDER_W-1:0] win_dist(
    input logic [ORDER_W-1:0] order,
    input logic [ORDER_W-1:0] nxt
  );
    return order - nxt;
  endfunction

endpackage

// File: rtl/rvfi_serial_slots.sv
// Reorder buffer storage: DEPTH records with NRET write ports, one read port
// and the occupancy vector. Writers guarantee distinct, unoccupied slots.
module rvfi_serial_slots
  import rvfi_serial_pkg::*;
#(
  parameter int unsigned NRET  = 1,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 64
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [NRET-1:0]                 wr_en,
  input  logic [NRET*$clog2(DEPTH)-1:0]   wr_idx,
  input  logic [NRET*W-1:0]               wr_data,
  input  logic [$clog2(DEPTH)-1:0]        rd_idx,
  input  logic                            rd_clr,
  output logic [W-1:0]                    rd_data_c,
  output logic                            rd_occ_c,
  output logic [DEPTH-1:0]                occ,
  output logic [DEPTH-1:0]                occ_next_c
);

  localparam int unsigned IW = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [DEPTH-1:0] set_c;
  logic [DEPTH-1:0] clr_c;

  always_comb begin
    set_c = '0;
    for (int c = 0; c < NRET; c++) begin
      if (wr_en[c]) set_c[wr_idx[c*IW +: IW]] = 1'b1;
    end
    clr_c      = rd_clr ? (DEPTH'(1) << rd_idx) : '0;
    occ_next_c = (occ & ~clr_c) | set_c;
  end

  always_ff @(posedge clk) begin
    if (!resetn) occ <= '0;
    else         occ <= occ_next_c;
  end

  // Slot contents need no reset: they are only read behind an occupied bit.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NRET; c++) begin
      if (wr_en[c]) mem_q[wr_idx[c*IW +: IW]] <= wr_data[c*W +: W];
    end
  end

  assign rd_data_c = mem_q[rd_idx];
  assign rd_occ_c  = occ[rd_idx];

endmodule

// File: rtl/rvfi_order_serializer.sv
// Reorders a multi-channel RVFI retirement stream by rvfi_order and replays it
// in program order, one instruction per cycle, on a single-channel bus.
`ifndef RISCV_FORMAL_NRET
`define RISCV_FORMAL_NRET 1
`endif
`ifndef RISCV_FORMAL_XLEN
`define RISCV_FORMAL_XLEN 32
`endif

module rvfi_order_serializer
  import rvfi_serial_pkg::*;
#(
  parameter int unsigned NRET  = `RISCV_FORMAL_NRET,
  parameter int unsigned XLEN  = `RISCV_FORMAL_XLEN,
  parameter int unsigned DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NRET-1:0]           rvfi_valid,
  input  logic [NRET*8-1:0]         rvfi_order,
  input  logic [NRET*32-1:0]        rvfi_insn,
  input  logic [NRET*5-1:0]         rvfi_rs1,
  input  logic [NRET*5-1:0]         rvfi_rs2,
  input  logic [NRET*5-1:0]         rvfi_rd,
  input  logic [NRET-1:0]           rvfi_trap,
  input  logic [NRET*XLEN-1:0]      rvfi_pre_pc,
  input  logic [NRET*XLEN-1:0]      rvfi_pre_rs1,
  input  logic [NRET*XLEN-1:0]      rvfi_pre_rs2,
  input  logic [NRET*XLEN-1:0]      rvfi_post_pc,
  input  logic [NRET*XLEN-1:0]      rvfi_post_rd,
  input  logic [NRET*XLEN-1:0]      rvfi_mem_addr,
  input  logic [NRET*XLEN-1:0]      rvfi_mem_rdata,
  input  logic [NRET*XLEN-1:0]      rvfi_mem_wdata,
  input  logic [NRET*XLEN/8-1:0]    rvfi_mem_rmask,
  input  logic [NRET*XLEN/8-1:0]    rvfi_mem_wmask,
  output logic                      ser_valid,
  output logic [7:0]                ser_order,
  output logic [31:0]               ser_insn,
  output logic [4:0]                ser_rs1,
  output logic [4:0]                ser_rs2,
  output logic [4:0]                ser_rd,
  output logic                      ser_trap,
  output logic [XLEN-1:0]           ser_pre_pc,
  output logic [XLEN-1:0]           ser_pre_rs1,
  output logic [XLEN-1:0]           ser_pre_rs2,
  output logic [XLEN-1:0]           ser_post_pc,
  output logic [XLEN-1:0]           ser_post_rd,
  output logic [XLEN-1:0]           ser_mem_addr,
  output logic [XLEN-1:0]           ser_mem_rdata,
  output logic [XLEN-1:0]           ser_mem_wdata,
  output logic [XLEN/8-1:0]         ser_mem_rmask,
  output logic [XLEN/8-1:0]         ser_mem_wmask,
  output logic [$clog2(DEPTH):0]    pending,
  output logic                      err_window,
  output logic                      err_dup
);

  localparam int unsigned IW   = $clog2(DEPTH);
  localparam int unsigned PW   = IW + 1;
  localparam int unsigned MW   = XLEN / 8;
  localparam int unsigned W    = rec_width(XLEN);
  localparam int unsigned DOFF = data_off(XLEN);

  logic [7:0]         next_q;
  logic [W-1:0]       ser_q;
  logic [NRET-1:0]    wr_en_c;
  logic [NRET-1:0]    tgt_c;
  logic [NRET-1:0]    win_err_c;
  logic [NRET-1:0]    dup_err_c;
  logic [NRET*IW-1:0] wr_idx_c;
  logic [NRET*W-1:0]  wr_data_c;
  logic [7:0]         dist_c;
  logic [IW-1:0]      idx_c;
  logic               clash_c;
  logic [W-1:0]       rd_data_c;
  logic               rd_occ_c;
  logic [DEPTH-1:0]   occ;
  logic [DEPTH-1:0]   occ_next_c;
  rvfi_hdr_t          ser_hdr;

  for (genvar c = 0; c < NRET; c++) begin : g_pack
    assign wr_data_c[c*W +: W] = {
      rvfi_pre_pc[c*XLEN +: XLEN],   rvfi_pre_rs1[c*XLEN +: XLEN],
      rvfi_pre_rs2[c*XLEN +: XLEN],  rvfi_post_pc[c*XLEN +: XLEN],
      rvfi_post_rd[c*XLEN +: XLEN],  rvfi_mem_addr[c*XLEN +: XLEN],
      rvfi_mem_rdata[c*XLEN +: XLEN], rvfi_mem_wdata[c*XLEN +: XLEN],
      rvfi_mem_rmask[c*MW +: MW],    rvfi_mem_wmask[c*MW +: MW],
      pack_hdr(rvfi_order[c*8 +: 8], rvfi_insn[c*32 +: 32], rvfi_rs1[c*5 +: 5],
               rvfi_rs2[c*5 +: 5], rvfi_rd[c*5 +: 5], rvfi_trap[c])
    };
  end

  // Accept arbitration: window check first, then slot occupancy and
  // same-cycle collisions with any lower channel that targets a slot.
  always_comb begin
    wr_en_c   = '0;
    tgt_c     = '0;
    win_err_c = '0;
    dup_err_c = '0;
    wr_idx_c  = '0;
    dist_c    = '0;
    idx_c     = '0;
    clash_c   = 1'b0;
    for (int c = 0; c < NRET; c++) begin
      dist_c = win_dist(rvfi_order[c*8 +: 8], next_q);
      idx_c  = rvfi_order[c*8 +: IW];
      wr_idx_c[c*IW +: IW] = idx_c;
      clash_c = occ[idx_c];
      for (int k = 0; k < NRET; k++) begin
        if (k < c && tgt_c[k] && wr_idx_c[k*IW +: IW] == idx_c) clash_c = 1'b1;
      end
      if (resetn && rvfi_valid[c]) begin
        if (32'(dist_c) >= DEPTH) begin
          win_err_c[c] = 1'b1;
        end else begin
          tgt_c[c] = 1'b1;
          if (clash_c) dup_err_c[c] = 1'b1;
          else         wr_en_c[c]   = 1'b1;
        end
      end
    end
  end

  rvfi_serial_slots #(
    .NRET  (NRET),
    .DEPTH (DEPTH),
    .W     (W)
  ) u_slots (
    .clk        (clk),
    .resetn     (resetn),
    .wr_en      (wr_en_c),
    .wr_idx     (wr_idx_c),
    .wr_data    (wr_data_c),
    .rd_idx     (next_q[IW-1:0]),
    .rd_clr     (rd_occ_c && resetn),
    .rd_data_c  (rd_data_c),
    .rd_occ_c   (rd_occ_c),
    .occ        (occ),
    .occ_next_c (occ_next_c)
  );

  // Emit path, occupancy count and sticky error flags.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      next_q     <= '0;
      ser_valid  <= 1'b0;
      ser_q      <= '0;
      pending    <= '0;
      err_window <= 1'b0;
      err_dup    <= 1'b0;
    end else begin
      if (rd_occ_c) begin
        ser_valid <= 1'b1;
        ser_q     <= rd_data_c;
        next_q    <= next_q + 8'd1;
      end else begin
        ser_valid <= 1'b0;
      end
      pending    <= PW'($countones(occ_next_c));
      err_window <= err_window | (|win_err_c);
      err_dup    <= err_dup | (|dup_err_c);
    end
  end

  assign ser_hdr       = unpack_hdr(ser_q[HDR_W-1:0]);
  assign ser_order     = ser_hdr.order;
  assign ser_insn      = ser_hdr.insn;
  assign ser_rs1       = ser_hdr.rs1;
  assign ser_rs2       = ser_hdr.rs2;
  assign ser_rd        = ser_hdr.rd;
  assign ser_trap      = ser_hdr.trap;
  assign ser_mem_wmask = ser_q[HDR_W +: MW];
  assign ser_mem_rmask = ser_q[HDR_W+MW +: MW];
  assign ser_mem_wdata = ser_q[DOFF +: XLEN];
  assign ser_mem_rdata = ser_q[DOFF+XLEN +: XLEN];
  assign ser_mem_addr  = ser_q[DOFF+2*XLEN +: XLEN];
  assign ser_post_rd   = ser_q[DOFF+3*XLEN +: XLEN];
  assign ser_post_pc   = ser_q[DOFF+4*XLEN +: XLEN];
  assign ser_pre_rs2   = ser_q[DOFF+5*XLEN +: XLEN];
  assign ser_pre_rs1   = ser_q[DOFF+6*XLEN +: XLEN];
  assign ser_pre_pc    = ser_q[DOFF+7*XLEN +: XLEN];

`ifdef RISCV_FORMAL
  logic seen_q;
  logic first_zero_c;

  always_ff @(posedge clk) begin
    if (!resetn)           seen_q <= 1'b0;
    else if (|rvfi_valid)  seen_q <= 1'b1;
  end

  always_comb begin
    first_zero_c = 1'b0;
    for (int c = 0; c < NRET; c++) begin
      if (rvfi_valid[c] && rvfi_order[c*8 +: 8] == 8'd0) first_zero_c = 1'b1;
    end
  end

  // Error flags are visible one cycle after the offending input.
  always_ff @(posedge clk) begin
    if (resetn && !seen_q && |rvfi_valid) assume (first_zero_c);
    if (resetn) assert (!err_window && !err_dup);
  end
`endif

endmodule

// File: tb/tb_rvfi_order_serializer.sv
// Bench for rvfi_order_serializer: table vectors, directed corner sequences
// and random traffic against an order-keyed reference model.
module tb_rvfi_order_serializer;

  localparam int unsigned NRET  = 2;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned MW    = XLEN / 8;
  localparam int unsigned PW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [7:0]        order;
    logic [31:0]       insn;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic              trap;
    logic [8*XLEN-1:0] x;
    logic [MW-1:0]     rmask;
    logic [MW-1:0]     wmask;
  } ent_t;
  localparam int unsigned EW = $bits(ent_t);

  typedef struct {
    bit [1:0]   v;
    logic [7:0] o0;
    logic [7:0] o1;
    bit         ev;
    logic [7:0] eord;
    int         epend;
    bit         ew;
    bit         ed;
  } vec_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [NRET-1:0]        rvfi_valid;
  logic [NRET*8-1:0]      rvfi_order;
  logic [NRET*32-1:0]     rvfi_insn;
  logic [NRET*5-1:0]      rvfi_rs1, rvfi_rs2, rvfi_rd;
  logic [NRET-1:0]        rvfi_trap;
  logic [NRET*XLEN-1:0]   rvfi_pre_pc, rvfi_pre_rs1, rvfi_pre_rs2, rvfi_post_pc, rvfi_post_rd;
  logic [NRET*XLEN-1:0]   rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
  logic [NRET*MW-1:0]     rvfi_mem_rmask, rvfi_mem_wmask;
  logic                   ser_valid;
  logic [7:0]             ser_order;
  logic [31:0]            ser_insn;
  logic [4:0]             ser_rs1, ser_rs2, ser_rd;
  logic                   ser_trap;
  logic [XLEN-1:0]        ser_pre_pc, ser_pre_rs1, ser_pre_rs2, ser_post_pc, ser_post_rd;
  logic [XLEN-1:0]        ser_mem_addr, ser_mem_rdata, ser_mem_wdata;
  logic [MW-1:0]          ser_mem_rmask, ser_mem_wmask;
  logic [PW-1:0]          pending;
  logic                   err_window, err_dup;

  rvfi_order_serializer #(.NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
    .rvfi_rs1(rvfi_rs1), .rvfi_rs2(rvfi_rs2), .rvfi_rd(rvfi_rd), .rvfi_trap(rvfi_trap),
    .rvfi_pre_pc(rvfi_pre_pc), .rvfi_pre_rs1(rvfi_pre_rs1), .rvfi_pre_rs2(rvfi_pre_rs2),
    .rvfi_post_pc(rvfi_post_pc), .rvfi_post_rd(rvfi_post_rd), .rvfi_mem_addr(rvfi_mem_addr),
    .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata),
    .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
    .ser_valid(ser_valid), .ser_order(ser_order), .ser_insn(ser_insn),
    .ser_rs1(ser_rs1), .ser_rs2(ser_rs2), .ser_rd(ser_rd), .ser_trap(ser_trap),
    .ser_pre_pc(ser_pre_pc), .ser_pre_rs1(ser_pre_rs1), .ser_pre_rs2(ser_pre_rs2),
    .ser_post_pc(ser_post_pc), .ser_post_rd(ser_post_rd), .ser_mem_addr(ser_mem_addr),
    .ser_mem_rdata(ser_mem_rdata), .ser_mem_wdata(ser_mem_wdata),
    .ser_mem_rmask(ser_mem_rmask), .ser_mem_wmask(ser_mem_wmask),
    .pending(pending), .err_window(err_window), .err_dup(err_dup)
  );

  int   checks = 0;
  int   errors = 0;
  ent_t ch_ent [NRET];

  // Reference model: entries held by order value, not by slot.
  ent_t m_buf [int];
  bit   m_taken [int];
  ent_t m_add [$];
  int   m_next;
  bit   m_valid;
  ent_t m_out;
  bit   m_errw, m_errd;

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t ser_ent();
    ent_t e;
    e.order = ser_order; e.insn = ser_insn; e.rs1 = ser_rs1; e.rs2 = ser_rs2;
    e.rd = ser_rd; e.trap = ser_trap; e.rmask = ser_mem_rmask; e.wmask = ser_mem_wmask;
    e.x[0*XLEN +: XLEN] = ser_pre_pc;    e.x[1*XLEN +: XLEN] = ser_pre_rs1;
    e.x[2*XLEN +: XLEN] = ser_pre_rs2;   e.x[3*XLEN +: XLEN] = ser_post_pc;
    e.x[4*XLEN +: XLEN] = ser_post_rd;   e.x[5*XLEN +: XLEN] = ser_mem_addr;
    e.x[6*XLEN +: XLEN] = ser_mem_rdata; e.x[7*XLEN +: XLEN] = ser_mem_wdata;
    return e;
  endfunction

  // Present a fresh random payload with the given order on channel c.
  task automatic put(input int c, input logic [7:0] ord);
    ent_t e;
    e.order = ord; e.insn = $urandom; e.rs1 = 5'($urandom); e.rs2 = 5'($urandom);
    e.rd = 5'($urandom); e.trap = 1'($urandom);
    e.rmask = MW'($urandom); e.wmask = MW'($urandom);
    for (int i = 0; i < 8; i++) e.x[i*XLEN +: XLEN] = $urandom;
    ch_ent[c] = e;
    rvfi_valid[c] = 1'b1;
    rvfi_order[c*8 +: 8] = e.order;  rvfi_insn[c*32 +: 32] = e.insn;
    rvfi_rs1[c*5 +: 5] = e.rs1;      rvfi_rs2[c*5 +: 5] = e.rs2;
    rvfi_rd[c*5 +: 5] = e.rd;        rvfi_trap[c] = e.trap;
    rvfi_mem_rmask[c*MW +: MW] = e.rmask; rvfi_mem_wmask[c*MW +: MW] = e.wmask;
    rvfi_pre_pc[c*XLEN +: XLEN]    = e.x[0*XLEN +: XLEN];
    rvfi_pre_rs1[c*XLEN +: XLEN]   = e.x[1*XLEN +: XLEN];
    rvfi_pre_rs2[c*XLEN +: XLEN]   = e.x[2*XLEN +: XLEN];
    rvfi_post_pc[c*XLEN +: XLEN]   = e.x[3*XLEN +: XLEN];
    rvfi_post_rd[c*XLEN +: XLEN]   = e.x[4*XLEN +: XLEN];
    rvfi_mem_addr[c*XLEN +: XLEN]  = e.x[5*XLEN +: XLEN];
    rvfi_mem_rdata[c*XLEN +: XLEN] = e.x[6*XLEN +: XLEN];
    rvfi_mem_wdata[c*XLEN +: XLEN] = e.x[7*XLEN +: XLEN];
  endtask

  // One clock: advance the model on the same inputs, then compare everything.
  task automatic tick();
    bit emit;
    int d, key;
    @(posedge clk);
    if (!resetn) begin
      m_next = 0; m_buf.delete(); m_valid = 0; m_out = '0; m_errw = 0; m_errd = 0;
    end else begin
      m_taken.delete();
      m_add.delete();
      emit = m_buf.exists(m_next);
      for (int c = 0; c < NRET; c++) begin
        if (rvfi_valid[c]) begin
          key = int'(ch_ent[c].order);
          d = (key - m_next + 256) % 256;
          if (d >= int'(DEPTH)) m_errw = 1;
          else if (m_buf.exists(key) || m_taken.exists(key)) m_errd = 1;
          else begin
            m_taken[key] = 1;
            m_add.push_back(ch_ent[c]);
          end
        end
      end
      if (emit) begin
        m_out = m_buf[m_next];
        m_buf.delete(m_next);
        m_next = (m_next + 1) % 256;
        m_valid = 1;
      end else begin
        m_valid = 0;
      end
      foreach (m_add[i]) m_buf[int'(m_add[i].order)] = m_add[i];
    end
    #1;
    chk("ser_valid", ser_valid, m_valid);
    chk("pending", pending, m_buf.num());
    chk("err_window", err_window, m_errw);
    chk("err_dup", err_dup, m_errd);
    chk("ser_data", ser_ent(), m_out);
    rvfi_valid = '0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  vec_t       tbl [12];
  ent_t       saved;
  logic [7:0] wexp [4];
  bit         got;

  initial begin
    resetn = 1'b0;
    rvfi_valid = '0; rvfi_order = '0; rvfi_insn = '0; rvfi_rs1 = '0; rvfi_rs2 = '0;
    rvfi_rd = '0; rvfi_trap = '0; rvfi_pre_pc = '0; rvfi_pre_rs1 = '0; rvfi_pre_rs2 = '0;
    rvfi_post_pc = '0; rvfi_post_rd = '0; rvfi_mem_addr = '0; rvfi_mem_rdata = '0;
    rvfi_mem_wdata = '0; rvfi_mem_rmask = '0; rvfi_mem_wmask = '0;

    tick();
    chk("rst_valid", ser_valid, 1'b0);
    chk("rst_pending", pending, 0);
    chk("rst_data", ser_ent(), '0);
    resetn = 1'b1;

    // In-order pairs, then a reordered trio; expectations are post-edge values.
    tbl[0]  = '{2'b11, 8'd0, 8'd1, 1'b0, 8'd0, 2, 1'b0, 1'b0};
    tbl[1]  = '{2'b11, 8'd2, 8'd3, 1'b1, 8'd0, 3, 1'b0, 1'b0};
    tbl[2]  = '{2'b00, 8'd0, 8'd0, 1'b1, 8'd1, 2, 1'b0, 1'b0};
    tbl[3]  = '{2'b00, 8'd0, 8'd0, 1'b1, 8'd2, 1, 1'b0, 1'b0};
    tbl[4]  = '{2'b00, 8'd0, 8'd0, 1'b1, 8'd3, 0, 1'b0, 1'b0};
    tbl[5]  = '{2'b00, 8'd0, 8'd0, 1'b0, 8'd3, 0, 1'b0, 1'b0};
    tbl[6]  = '{2'b01, 8'd6, 8'd0, 1'b0, 8'd3, 1, 1'b0, 1'b0};
    tbl[7]  = '{2'b01, 8'd4, 8'd0, 1'b0, 8'd3, 2, 1'b0, 1'b0};
    tbl[8]  = '{2'b01, 8'd5, 8'd0, 1'b1, 8'd4, 2, 1'b0, 1'b0};
    tbl[9]  = '{2'b00, 8'd0, 8'd0, 1'b1, 8'd5, 1, 1'b0, 1'b0};
    tbl[10] = '{2'b00, 8'd0, 8'd0, 1'b1, 8'd6, 0, 1'b0, 1'b0};
    tbl[11] = '{2'b00, 8'd0, 8'd0, 1'b0, 8'd6, 0, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].v[0]) put(0, tbl[i].o0);
      if (tbl[i].v[1]) put(1, tbl[i].o1);
      tick();
      chk($sformatf("tbl%0d_valid", i), ser_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_order", i), ser_order, tbl[i].eord);
      chk($sformatf("tbl%0d_pending", i), pending, tbl[i].epend);
      chk($sformatf("tbl%0d_errs", i), {err_window, err_dup}, {tbl[i].ew, tbl[i].ed});
    end

    // Window edge: d=DEPTH-1 accepted, d=DEPTH flagged; order 0 still emits.
    do_reset();
    put(0, 8'd7); put(1, 8'd8);
    tick();
    chk("win_flag", err_window, 1'b1);
    chk("win_pending", pending, 1);
    put(0, 8'd0);
    tick();
    tick();
    chk("win_emit0", {ser_valid, ser_order}, {1'b1, 8'd0});
    chk("win_sticky", err_window, 1'b1);

    // Duplicates: same-cycle collision keeps channel 0; later copy is dropped.
    do_reset();
    put(0, 8'd3); put(1, 8'd3);
    saved = ch_ent[0];
    tick();
    chk("dup_flag", err_dup, 1'b1);
    chk("dup_pending", pending, 1);
    put(0, 8'd3);
    tick();
    chk("dup_pending2", pending, 1);
    put(0, 8'd0); put(1, 8'd1);
    tick();
    put(0, 8'd2);
    tick();
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (ser_valid && ser_order == 8'd3) begin
        got = 1;
        chk("dup_keep", ser_ent(), saved);
      end
    end
    chk("dup_seen", got, 1'b1);

    // Wrap through 255 -> 0 with a contiguous output run.
    do_reset();
    for (int i = 0; i < 254; i++) begin
      put(0, 8'(i));
      tick();
    end
    tick();
    put(0, 8'd254); put(1, 8'd255);
    tick();
    put(0, 8'd0); put(1, 8'd1);
    wexp[0] = 8'd254; wexp[1] = 8'd255; wexp[2] = 8'd0; wexp[3] = 8'd1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("wrap%0d", i), {ser_valid, ser_order}, {1'b1, wexp[i]});
    end
    chk("wrap_errs", {err_window, err_dup}, 2'b00);

    // Reset with four entries pending.
    do_reset();
    put(0, 8'd1); put(1, 8'd2);
    tick();
    put(0, 8'd3); put(1, 8'd4);
    tick();
    chk("rst4_pending", pending, 4);
    resetn = 1'b0;
    put(0, 8'd0);
    tick();
    resetn = 1'b1;
    chk("rst4_cleared", {ser_valid, pending}, '0);
    put(0, 8'd0);
    tick();
    chk("rst4_lat1", ser_valid, 1'b0);
    tick();
    chk("rst4_lat2", {ser_valid, ser_order}, {1'b1, 8'd0});

    // Random traffic, mostly inside the window, with occasional resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      resetn = ($urandom_range(0, 99) != 0);
      for (int c = 0; c < NRET; c++) begin
        if ($urandom_range(0, 99) < 45) begin
          if ($urandom_range(0, 15) == 0) put(c, 8'($urandom));
          else put(c, 8'((m_next + int'($urandom_range(0, DEPTH - 1))) % 256));
        end
      end
      tick();
    end
    resetn = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
